// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the last-level cache, the cache-line adaptor and main memory.
// The slave view belongs to the adaptor; the master view is the surrounding
// environment, which drives the cache requests and the memory beats.
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  // cache side
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  // memory side
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read or write into a single multi-beat memory burst.
// The line is held in an internal buffer: read beats are assembled into it
// (beat 0 in the lowest-order bits) and write beats are sliced out of it.
// Completion is reported to the cache with a one-cycle resp_o pulse.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,   // synchronous, active low
  cacheline_adaptor_if.slave   bus
);

  localparam int BURSTS      = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W       = $clog2(BURSTS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  // Clears the byte offset inside a line so memory always sees aligned addresses.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [LINE_WIDTH-1:0]  buffer_r;
  logic [ADDR_WIDTH-1:0]  address_r;
  logic                   read_r;
  logic                   write_r;
  logic                   resp_r;
  logic [BURST_WIDTH-1:0] burst_s;

  // Request acceptance, beat sequencing and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      buffer_r  <= '0;
      address_r <= '0;
      read_r    <= 1'b0;
      write_r   <= 1'b0;
      resp_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_r <= 1'b0;
          // A read wins over a simultaneous write; the write is dropped.
          if (bus.read_i) begin
            address_r <= bus.address_i & ADDR_MASK;
            cnt_r     <= '0;
            read_r    <= 1'b1;
            write_r   <= 1'b0;
            state_r   <= READ;
          end else if (bus.write_i) begin
            address_r <= bus.address_i & ADDR_MASK;
            buffer_r  <= bus.line_i;
            cnt_r     <= '0;
            read_r    <= 1'b0;
            write_r   <= 1'b1;
            state_r   <= WRITE;
          end else begin
            read_r    <= 1'b0;
            write_r   <= 1'b0;
            state_r   <= IDLE;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            buffer_r[int'(cnt_r) * BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_BEAT) begin
              read_r  <= 1'b0;
              resp_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= READ;
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_BEAT) begin
              write_r <= 1'b0;
              resp_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= WRITE;
            end
          end else begin
            state_r <= WRITE;
          end
        end
        DONE: begin
          // Completion pulse lasts exactly one cycle; memory strobes are ignored.
          resp_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          read_r  <= 1'b0;
          write_r <= 1'b0;
          resp_r  <= 1'b0;
        end
      endcase
    end
  end

  // Current write beat taken straight from the buffer; quiet outside a write burst.
  always_comb begin
    burst_s = '0;
    if (write_r) begin
      burst_s = buffer_r[int'(cnt_r) * BURST_WIDTH +: BURST_WIDTH];
    end else begin
      burst_s = '0;
    end
  end

  assign bus.line_o    = buffer_r;
  assign bus.address_o = address_r;
  assign bus.read_o    = read_r;
  assign bus.write_o   = write_r;
  assign bus.resp_o    = resp_r;
  assign bus.burst_o   = burst_s;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. A transaction-level model keeps the
// line the cache should see and the aligned address memory should see; each task
// drives one scenario and compares the DUT against the expected behaviour cycle
// by cycle.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Transaction-level model state.
  logic [255:0] model_line;
  logic [31:0]  model_addr;

  cacheline_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) bus ();

  cacheline_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // One line read; beat b of the burst is beats[64*b +: 64].
  task automatic do_read(input logic [31:0] addr, input logic [255:0] beats,
                         input int gap_max, input bit with_write);
    logic [31:0] exp_addr;
    int          gaps;
    exp_addr = addr & 32'hFFFF_FFE0;
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    bus.write_i   = with_write;
    bus.line_i    = rand256();
    bus.resp_i    = 1'b0;
    tick();
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = $urandom;
    model_addr    = exp_addr;
    total++;
    if (bus.read_o !== 1'b1 || bus.write_o !== 1'b0) begin
      bad++;
      $display("FAIL rd_req: read_o=%b write_o=%b want 1 0", bus.read_o, bus.write_o);
    end
    total++;
    if (bus.address_o !== exp_addr) begin
      bad++;
      $display("FAIL rd_addr: got %h want %h", bus.address_o, exp_addr);
    end
    for (int b = 0; b < 4; b++) begin
      gaps = $urandom_range(gap_max, 0);
      for (int g = 0; g < gaps; g++) begin
        bus.resp_i  = 1'b0;
        bus.burst_i = rand64();
        tick();
        total++;
        if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin
          bad++;
          $display("FAIL rd_gap: read_o=%b resp_o=%b want 1 0", bus.read_o, bus.resp_o);
        end
      end
      bus.resp_i  = 1'b1;
      bus.burst_i = beats[b*64 +: 64];
      tick();
      bus.resp_i  = 1'b0;
      bus.burst_i = rand64();
      if (b < 3) begin
        total++;
        if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.burst_o !== 64'h0) begin
          bad++;
          $display("FAIL rd_beat%0d: read_o=%b resp_o=%b burst_o=%h want 1 0 0",
                   b, bus.read_o, bus.resp_o, bus.burst_o);
        end
      end else begin
        total++;
        if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b1) begin
          bad++;
          $display("FAIL rd_done: read_o=%b write_o=%b resp_o=%b want 0 0 1",
                   bus.read_o, bus.write_o, bus.resp_o);
        end
        total++;
        if (bus.line_o !== beats) begin
          bad++;
          $display("FAIL rd_line: got %h want %h", bus.line_o, beats);
        end
      end
    end
    model_line = beats;
    tick();
    total++;
    if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0 || bus.line_o !== model_line
        || bus.address_o !== model_addr) begin
      bad++;
      $display("FAIL rd_after: resp_o=%b read_o=%b line_o=%h addr=%h want 0 0 %h %h",
               bus.resp_o, bus.read_o, bus.line_o, bus.address_o, model_line, model_addr);
    end
  endtask

  // One line write; memory must see the line's beats lowest-order first.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int gap_max);
    logic [31:0] exp_addr;
    int          gaps;
    exp_addr = addr & 32'hFFFF_FFE0;
    bus.address_i = addr;
    bus.write_i   = 1'b1;
    bus.read_i    = 1'b0;
    bus.line_i    = line;
    bus.resp_i    = 1'b0;
    tick();
    bus.write_i   = 1'b0;
    bus.line_i    = rand256();
    bus.address_i = $urandom;
    model_addr    = exp_addr;
    total++;
    if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.burst_o !== line[63:0]) begin
      bad++;
      $display("FAIL wr_req: write_o=%b read_o=%b burst_o=%h want 1 0 %h",
               bus.write_o, bus.read_o, bus.burst_o, line[63:0]);
    end
    total++;
    if (bus.address_o !== exp_addr) begin
      bad++;
      $display("FAIL wr_addr: got %h want %h", bus.address_o, exp_addr);
    end
    for (int b = 0; b < 4; b++) begin
      gaps = $urandom_range(gap_max, 0);
      for (int g = 0; g < gaps; g++) begin
        bus.resp_i  = 1'b0;
        tick();
        total++;
        if (bus.write_o !== 1'b1 || bus.burst_o !== line[b*64 +: 64]) begin
          bad++;
          $display("FAIL wr_gap%0d: write_o=%b burst_o=%h want 1 %h",
                   b, bus.write_o, bus.burst_o, line[b*64 +: 64]);
        end
      end
      bus.resp_i  = 1'b1;
      bus.burst_i = rand64();
      tick();
      bus.resp_i  = 1'b0;
      if (b < 3) begin
        total++;
        if (bus.write_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.burst_o !== line[(b+1)*64 +: 64]) begin
          bad++;
          $display("FAIL wr_beat%0d: write_o=%b resp_o=%b burst_o=%h want 1 0 %h",
                   b, bus.write_o, bus.resp_o, bus.burst_o, line[(b+1)*64 +: 64]);
        end
      end else begin
        total++;
        if (bus.write_o !== 1'b0 || bus.read_o !== 1'b0 || bus.resp_o !== 1'b1
            || bus.burst_o !== 64'h0) begin
          bad++;
          $display("FAIL wr_done: write_o=%b read_o=%b resp_o=%b burst_o=%h want 0 0 1 0",
                   bus.write_o, bus.read_o, bus.resp_o, bus.burst_o);
        end
      end
    end
    model_line = line;
    tick();
    total++;
    if (bus.resp_o !== 1'b0 || bus.write_o !== 1'b0 || bus.line_o !== model_line) begin
      bad++;
      $display("FAIL wr_after: resp_o=%b write_o=%b line_o=%h want 0 0 %h",
               bus.resp_o, bus.write_o, bus.line_o, model_line);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.line_i    = rand256();
    bus.address_i = $urandom;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = rand64();
    bus.resp_i    = 1'b0;
    tick();
    tick();
    model_line = 256'h0;
    model_addr = 32'h0;
    total++;
    if (bus.line_o !== 256'h0 || bus.burst_o !== 64'h0 || bus.address_o !== 32'h0
        || bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: line=%h burst=%h addr=%h rd=%b wr=%b resp=%b want all 0",
               bus.line_o, bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.resp_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_directed();
    logic [255:0] beats;
    beats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, beats, 0, 1'b0);
    total++;
    if (bus.address_o !== 32'h0000_1220) begin
      bad++;
      $display("FAIL rd_directed_addr: got %h want 00001220", bus.address_o);
    end
  endtask

  task automatic test_write_directed();
    logic [255:0] line;
    line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_write(32'h0000_ABCF, line, 0);
  endtask

  task automatic test_read_gaps();
    for (int i = 0; i < 8; i++) begin
      do_read($urandom, rand256(), 3, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      do_write($urandom, rand256(), 3);
    end
  endtask

  task automatic test_both_requests();
    for (int i = 0; i < 3; i++) begin
      do_read($urandom, rand256(), 1, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    bus.address_i = 32'h0000_5A5F;
    bus.read_i    = 1'b1;
    bus.resp_i    = 1'b0;
    tick();
    bus.read_i    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = rand64();
      tick();
    end
    rst           = 1'b0;
    bus.burst_i   = rand64();
    tick();
    bus.resp_i    = 1'b0;
    model_line    = 256'h0;
    model_addr    = 32'h0;
    total++;
    if (bus.line_o !== 256'h0 || bus.burst_o !== 64'h0 || bus.address_o !== 32'h0
        || bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: line=%h burst=%h addr=%h rd=%b wr=%b resp=%b want all 0",
               bus.line_o, bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.resp_o);
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0 || bus.line_o !== 256'h0) begin
      bad++;
      $display("FAIL reset_mid_idle: rd=%b resp=%b line=%h want 0 0 0",
               bus.read_o, bus.resp_o, bus.line_o);
    end
    do_read($urandom, rand256(), 0, 1'b0);
  endtask

  task automatic test_idle_resp();
    for (int i = 0; i < 5; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = rand64();
      tick();
      total++;
      if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0
          || bus.burst_o !== 64'h0 || bus.line_o !== model_line
          || bus.address_o !== model_addr) begin
        bad++;
        $display("FAIL idle_resp: rd=%b wr=%b resp=%b burst=%h line=%h addr=%h want 0 0 0 0 %h %h",
                 bus.read_o, bus.write_o, bus.resp_o, bus.burst_o, bus.line_o,
                 bus.address_o, model_line, model_addr);
      end
    end
    bus.resp_i = 1'b0;
    do_read($urandom, rand256(), 0, 1'b0);
    do_write($urandom, rand256(), 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_read($urandom, rand256(), 0, 1'b0);
      end else begin
        do_write($urandom, rand256(), 0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_directed();
    test_write_directed();
    test_read_gaps();
    test_both_requests();
    test_reset_mid();
    test_idle_resp();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
